joy_serial_scan_ctrl: RTL and testbench
=======================================

Name: joy_serial_scan_ctrl

Overview:
- Scan scheduler and sequencer for the parallel-in/serial-out shift-register chain that carries both joystick ports.
- Generates the active-low load strobe and the shift clock, and captures NUM_BITS serial bits into a frame.
- Publishes each frame with a one-cycle valid pulse.
- Scans run periodically (auto mode), on demand (request input), or both; a single scan engine is shared between the two requesters.

Parameters:
- CLK_DIV, 4, system clocks per tick; legal range >= 2. All chain timing advances on ticks.
- NUM_BITS, 16, bits per frame; legal range 1..32.
- LOAD_TICKS, 2, ticks joy_load_o is held low; legal range >= 1.
- SCAN_PERIOD, 64, ticks from one auto scan start to the next; must exceed LOAD_TICKS + 2*NUM_BITS + 1.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- auto_en_i  in  1  enables periodic scans
- scan_req_i  in  1  one-cycle pulse requesting an immediate scan
- joy_data_i  in  1  serial data from chain output (QH)
- joy_clk_o  out  1  chain shift clock, registered
- joy_load_o  out  1  chain parallel-load strobe, active low, registered
- frame_o  out  NUM_BITS  last completed frame; first sampled bit is at MSB
- frame_valid_o  out  1  one-cycle pulse when frame_o updates
- busy_o  out  1  high while the state is not IDLE

Behaviour:
- Reset values: joy_clk_o=0, joy_load_o=1, frame_o=all ones, frame_valid_o=0, busy_o=0, state=IDLE, prescaler=0, period counter=0, pending request=0.
- Reset applied mid-scan aborts the scan; all values return to reset values at the next clock edge, and frame_o is not updated.
- Prescaler: counts 0..CLK_DIV-1; tick=1 in the cycle where count==CLK_DIV-1, then wraps to 0.
- Period counter: advances on each tick while auto_en_i=1. Auto expiry when it reaches SCAN_PERIOD-1. Reloads to 0 on every scan start, whatever the scan's source. Holds its value while auto_en_i=0.
- Pending request: scan_req_i sets it. It is cleared when a scan starts. If scan_req_i arrives during a scan, exactly one further scan follows; extra pulses in the same scan are merged.
- IDLE:
  - On a tick with a pending request or auto expiry, go to LOAD and set joy_load_o=0.
  - A simultaneous request and expiry cause one scan only; both are satisfied.
- LOAD:
  - Hold joy_load_o=0 for LOAD_TICKS ticks.
  - On the last of those ticks, set joy_load_o=1, clear the bit counter and enter SHIFT.
- SHIFT, two ticks per bit:
  - Phase A tick: shift left, shreg <= {shreg[NUM_BITS-2:0], joy_data_i}, and set joy_clk_o=1.
  - Phase B tick: set joy_clk_o=0 and increment the bit counter.
  - On the phase B tick of bit NUM_BITS-1, go to DONE.
  - Data is always sampled while joy_clk_o=0, before its rising edge.
- DONE, lasts one clock cycle, not tick-aligned:
  - frame_o <= shreg and frame_valid_o=1 for that cycle.
  - Then return to IDLE.
  - busy_o falls in the cycle after DONE.
- Deasserting auto_en_i mid-scan does not abort the scan.
- Scan duration from start tick to DONE: (LOAD_TICKS + 2*NUM_BITS) ticks plus 1 cycle.
- frame_o is stable between valid pulses.

Optional Feature:
- Macro: JOY_SCAN_DEBOUNCE_EN.
- Defined:
  - A held register keeps the previous raw frame.
  - In DONE, frame_o updates and frame_valid_o pulses only if shreg equals the held frame.
  - The held frame is always updated with shreg.
  - Reset value of the held frame is all ones.
  - A single-scan glitch therefore never reaches frame_o.
- Undefined: every completed scan updates frame_o and pulses frame_valid_o.

Test Plan:
- Reset then idle, auto_en_i=0, no request, 500 cycles -> joy_load_o=1, joy_clk_o=0, frame_o=16'hFFFF, no valid pulse.
- CLK_DIV=2, NUM_BITS=8, LOAD_TICKS=2; one scan_req_i pulse; chain model presents 8'hA5 MSB-first -> joy_load_o low for exactly 4 clocks, then 8 joy_clk_o pulses each 2 clocks high, frame_o=8'hA5 with a single valid pulse 37 clocks after the first start tick.
- Auto mode, SCAN_PERIOD=64, CLK_DIV=4 -> load falling edges exactly 256 clocks apart across 5 scans.
- Three scan_req_i pulses during a busy scan -> exactly one additional scan; scan_req_i coincident with auto expiry -> one scan only.
- rst_i asserted in the middle of SHIFT -> next edge gives joy_load_o=1, joy_clk_o=0, busy_o=0, and frame_o unchanged from its reset value.
- With JOY_SCAN_DEBOUNCE_EN: chain frames 8'h12, 8'h34, 8'h34 -> the first two give no valid pulse; the third gives frame_o=8'h34 with a valid pulse.

Source files
------------

// File: rtl/joy_serial_scan_ctrl.sv
// Load/shift sequencer for the parallel-in/serial-out chain carrying both joystick ports.
// Define JOY_SCAN_DEBOUNCE_EN to publish a frame only when two consecutive scans agree.
module joy_serial_scan_ctrl #(
    parameter int CLK_DIV     = 4,
    parameter int NUM_BITS    = 16,
    parameter int LOAD_TICKS  = 2,
    parameter int SCAN_PERIOD = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                auto_en_i,
    input  logic                scan_req_i,
    input  logic                joy_data_i,
    output logic                joy_clk_o,
    output logic                joy_load_o,
    output logic [NUM_BITS-1:0] frame_o,
    output logic                frame_valid_o,
    output logic                busy_o
);

    localparam int PRE_W  = $clog2(CLK_DIV);
    localparam int PER_W  = $clog2(SCAN_PERIOD);
    localparam int LOAD_W = $clog2(LOAD_TICKS + 1);
    localparam int BIT_W  = $clog2(NUM_BITS + 1);

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_DIV - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(SCAN_PERIOD - 1);
    localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(LOAD_TICKS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t              state;
    logic [PRE_W-1:0]    prescaler;
    logic [PER_W-1:0]    period_cnt;
    logic [LOAD_W-1:0]   load_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic                phase_b;
    logic                pending;
    logic [NUM_BITS-1:0] shreg;
    logic                tick;
    logic                auto_expire;
    logic                start_scan;

`ifdef JOY_SCAN_DEBOUNCE_EN
    logic [NUM_BITS-1:0] held;
`endif

    assign tick        = (prescaler == PRE_LAST);
    assign auto_expire = auto_en_i && (period_cnt == PER_LAST);
    // A request in the very cycle of the start tick is consumed by that scan too.
    assign start_scan  = tick && (state == ST_IDLE) && (pending || scan_req_i || auto_expire);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            prescaler     <= '0;
            period_cnt    <= '0;
            load_cnt      <= '0;
            bit_cnt       <= '0;
            phase_b       <= 1'b0;
            pending       <= 1'b0;
            shreg         <= '1;
            joy_clk_o     <= 1'b0;
            joy_load_o    <= 1'b1;
            frame_o       <= '1;
            frame_valid_o <= 1'b0;
            busy_o        <= 1'b0;
`ifdef JOY_SCAN_DEBOUNCE_EN
            held          <= '1;
`endif
        end else begin
            prescaler     <= tick ? '0 : prescaler + PRE_W'(1);
            pending       <= start_scan ? 1'b0 : (pending | scan_req_i);
            frame_valid_o <= 1'b0;

            // Period counter parks at expiry so a pending auto scan is never lost.
            if (start_scan) begin
                period_cnt <= '0;
            end else if (tick && auto_en_i && (period_cnt != PER_LAST)) begin
                period_cnt <= period_cnt + PER_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (start_scan) begin
                        state      <= ST_LOAD;
                        joy_load_o <= 1'b0;
                        load_cnt   <= '0;
                        busy_o     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (tick) begin
                        if (load_cnt == LOAD_LAST) begin
                            joy_load_o <= 1'b1;
                            bit_cnt    <= '0;
                            phase_b    <= 1'b0;
                            state      <= ST_SHIFT;
                        end else begin
                            load_cnt <= load_cnt + LOAD_W'(1);
                        end
                    end
                end
                ST_SHIFT: begin
                    // Sampling on phase A happens while joy_clk_o is still low.
                    if (tick) begin
                        if (!phase_b) begin
                            shreg     <= (shreg << 1) | NUM_BITS'(joy_data_i);
                            joy_clk_o <= 1'b1;
                            phase_b   <= 1'b1;
                        end else begin
                            joy_clk_o <= 1'b0;
                            phase_b   <= 1'b0;
                            bit_cnt   <= bit_cnt + BIT_W'(1);
                            if (bit_cnt == BIT_LAST) begin
                                state <= ST_DONE;
`ifdef JOY_SCAN_DEBOUNCE_EN
                                held <= shreg;
                                if (shreg == held) begin
                                    frame_o       <= shreg;
                                    frame_valid_o <= 1'b1;
                                end
`else
                                frame_o       <= shreg;
                                frame_valid_o <= 1'b1;
`endif
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_joy_serial_scan_ctrl.sv
// Self-checking bench for joy_serial_scan_ctrl with a behavioural PISO chain and a frame scoreboard.
// Honours JOY_SCAN_DEBOUNCE_EN when the design is built with it.
module tb_joy_serial_scan_ctrl;

    localparam int CLK_DIV     = 2;
    localparam int NUM_BITS    = 8;
    localparam int LOAD_TICKS  = 2;
    localparam int SCAN_PERIOD = 64;
    localparam int PERIOD_CLKS = SCAN_PERIOD * CLK_DIV;
    localparam int SCAN_CLKS   = (LOAD_TICKS + 2 * NUM_BITS) * CLK_DIV + 1;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    logic                auto_en_i = 1'b0;
    logic                scan_req_i = 1'b0;
    logic                joy_data_i;
    logic                joy_clk_o;
    logic                joy_load_o;
    logic [NUM_BITS-1:0] frame_o;
    logic                frame_valid_o;
    logic                busy_o;

    int vectors = 0;
    int miscompares = 0;

    logic [NUM_BITS-1:0] exp_q[$];
    logic [NUM_BITS-1:0] chain_word = '0;
    logic [NUM_BITS-1:0] chain = '1;
    logic                prev_load = 1'b1;
    logic                prev_jclk = 1'b0;
`ifdef JOY_SCAN_DEBOUNCE_EN
    logic [NUM_BITS-1:0] tb_held = '1;
`endif

    joy_serial_scan_ctrl #(
        .CLK_DIV    (CLK_DIV),
        .NUM_BITS   (NUM_BITS),
        .LOAD_TICKS (LOAD_TICKS),
        .SCAN_PERIOD(SCAN_PERIOD)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .auto_en_i    (auto_en_i),
        .scan_req_i   (scan_req_i),
        .joy_data_i   (joy_data_i),
        .joy_clk_o    (joy_clk_o),
        .joy_load_o   (joy_load_o),
        .frame_o      (frame_o),
        .frame_valid_o(frame_valid_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    assign joy_data_i = chain[NUM_BITS-1];

    // Chain model: parallel load while load is low, shift on each rising chain clock.
    // The loaded word is queued as an expected frame when load returns high.
    always @(posedge clk_i) begin
        prev_load <= joy_load_o;
        prev_jclk <= joy_clk_o;
        if (!joy_load_o) begin
            chain <= chain_word;
        end else if (joy_clk_o && !prev_jclk) begin
            chain <= {chain[NUM_BITS-2:0], 1'b1};
        end
        if (joy_load_o && !prev_load && !rst_i) begin
`ifdef JOY_SCAN_DEBOUNCE_EN
            if (chain == tb_held) exp_q.push_back(chain);
            tb_held <= chain;
`else
            exp_q.push_back(chain);
`endif
        end
`ifdef JOY_SCAN_DEBOUNCE_EN
        if (rst_i) tb_held <= '1;
`endif
    end

    task automatic test_reset();
        int obs[9];
        int expv[9];
        string names[9];
        rst_i = 1'b1;
        auto_en_i = 1'b0;
        scan_req_i = 1'b0;
        repeat (3) @(negedge clk_i);
        obs[0] = int'(joy_load_o);    expv[0] = 1;    names[0] = "reset_load";
        obs[1] = int'(joy_clk_o);     expv[1] = 0;    names[1] = "reset_jclk";
        obs[2] = int'(frame_o);       expv[2] = 'hFF; names[2] = "reset_frame";
        obs[3] = int'(frame_valid_o); expv[3] = 0;    names[3] = "reset_valid";
        obs[4] = int'(busy_o);        expv[4] = 0;    names[4] = "reset_busy";
        rst_i = 1'b0;
        for (int k = 5; k < 9; k++) obs[k] = 0;
        expv[5] = 0; names[5] = "idle_load_low_cycles";
        expv[6] = 0; names[6] = "idle_jclk_high_cycles";
        expv[7] = 0; names[7] = "idle_valid_pulses";
        expv[8] = 0; names[8] = "idle_frame_changes";
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_i);
            if (joy_load_o !== 1'b1) obs[5]++;
            if (joy_clk_o !== 1'b0) obs[6]++;
            if (frame_valid_o !== 1'b0) obs[7]++;
            if (frame_o !== 8'hFF) obs[8]++;
        end
        for (int k = 0; k < 9; k++) begin
            vectors++;
            if (obs[k] !== expv[k]) begin
                miscompares++;
                $display("[TB] FAIL %s: got %0h, expected %0h", names[k], obs[k], expv[k]);
            end
        end
    endtask

    task automatic test_single_scan();
        int load_low = 0, pulses = 0, bad_runs = 0, hi_run = 0, valids = 0;
        int first_low = -1, valid_at = -1;
        logic busy_at_valid = 1'b0, busy_after = 1'b1, prev_c = 1'b0;
        logic [NUM_BITS-1:0] e;
        chain_word = 8'hA5;
`ifdef JOY_SCAN_DEBOUNCE_EN
        @(negedge clk_i) scan_req_i = 1'b1;
        @(negedge clk_i) scan_req_i = 1'b0;
        repeat (SCAN_CLKS + 10) @(negedge clk_i);
`endif
        @(negedge clk_i) scan_req_i = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk_i);
            scan_req_i = 1'b0;
            if (!joy_load_o) begin
                load_low++;
                if (first_low < 0) first_low = i;
            end
            if (joy_clk_o) begin
                hi_run++;
                if (!prev_c) pulses++;
            end else begin
                if (prev_c && hi_run != CLK_DIV) bad_runs++;
                hi_run = 0;
            end
            prev_c = joy_clk_o;
            if (valid_at >= 0 && i == valid_at + 1) busy_after = busy_o;
            if (frame_valid_o) begin
                valids++;
                valid_at = i;
                busy_at_valid = busy_o;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL single_frame: valid with frame %h, nothing expected", frame_o);
                end else begin
                    e = exp_q.pop_front();
                    if (frame_o !== e || frame_o !== 8'hA5) begin
                        miscompares++;
                        $display("[TB] FAIL single_frame: got %h, expected %h", frame_o, e);
                    end
                end
            end
        end
        vectors += 6;
        if (load_low != LOAD_TICKS * CLK_DIV) begin
            miscompares++; $display("[TB] FAIL load_low_clocks: got %0d, expected %0d", load_low, LOAD_TICKS * CLK_DIV);
        end
        if (pulses != NUM_BITS || bad_runs != 0) begin
            miscompares++; $display("[TB] FAIL jclk_pulses: got %0d pulses (%0d bad widths), expected %0d", pulses, bad_runs, NUM_BITS);
        end
        if (valids != 1) begin
            miscompares++; $display("[TB] FAIL single_valid_count: got %0d, expected 1", valids);
        end
        if (valid_at - first_low != SCAN_CLKS - 1) begin
            miscompares++; $display("[TB] FAIL scan_latency: got %0d, expected %0d", valid_at - first_low + 1, SCAN_CLKS);
        end
        if (busy_at_valid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL busy_in_done: got %b, expected 1", busy_at_valid);
        end
        if (busy_after !== 1'b0) begin
            miscompares++; $display("[TB] FAIL busy_after_done: got %b, expected 0", busy_after);
        end
    endtask

    task automatic test_auto_period();
        logic [NUM_BITS-1:0] words[5] = '{8'h3C, 8'h3C, 8'hC3, 8'hC3, 8'h5A};
        int fall_at[5];
        int falls = 0, valids = 0, exp_valids;
        logic prev_l = 1'b1;
        logic [NUM_BITS-1:0] e;
`ifdef JOY_SCAN_DEBOUNCE_EN
        exp_valids = 2;
`else
        exp_valids = 5;
`endif
        auto_en_i = 1'b1;
        for (int i = 0; i < 6 * PERIOD_CLKS + 300; i++) begin
            @(negedge clk_i);
            if (!joy_load_o && prev_l) begin
                if (falls < 5) begin
                    fall_at[falls] = i;
                    chain_word = words[falls];
                end
                falls++;
            end
            prev_l = joy_load_o;
            if (frame_valid_o) begin
                valids++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL auto_frame: valid with frame %h, nothing expected", frame_o);
                end else begin
                    e = exp_q.pop_front();
                    if (frame_o !== e) begin
                        miscompares++;
                        $display("[TB] FAIL auto_frame: got %h, expected %h", frame_o, e);
                    end
                end
            end
            if (falls >= 5 && i > fall_at[4] + SCAN_CLKS + 4) break;
        end
        auto_en_i = 1'b0;
        vectors++;
        if (falls != 5) begin
            miscompares++;
            $display("[TB] FAIL auto_scan_count: got %0d, expected 5", falls);
        end else begin
            for (int k = 1; k < 5; k++) begin
                vectors++;
                if (fall_at[k] - fall_at[k-1] != PERIOD_CLKS) begin
                    miscompares++;
                    $display("[TB] FAIL auto_spacing_%0d: got %0d, expected %0d", k, fall_at[k] - fall_at[k-1], PERIOD_CLKS);
                end
            end
        end
        vectors++;
        if (valids != exp_valids) begin
            miscompares++;
            $display("[TB] FAIL auto_valid_count: got %0d, expected %0d", valids, exp_valids);
        end
    endtask

    task automatic test_back_to_back();
        int falls = 0, valids = 0, exp_valids;
        logic prev_l = 1'b1, busy_mid = 1'b0;
        logic [NUM_BITS-1:0] e;
`ifdef JOY_SCAN_DEBOUNCE_EN
        exp_valids = 1;
`else
        exp_valids = 2;
`endif
        auto_en_i = 1'b0;
        chain_word = 8'h69;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (!joy_load_o && prev_l) falls++;
            prev_l = joy_load_o;
            if (i == 10) busy_mid = busy_o;
            if (frame_valid_o) begin
                valids++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_frame: valid with frame %h, nothing expected", frame_o);
                end else begin
                    e = exp_q.pop_front();
                    if (frame_o !== e) begin
                        miscompares++;
                        $display("[TB] FAIL b2b_frame: got %h, expected %h", frame_o, e);
                    end
                end
            end
            scan_req_i = (i == 0 || i == 10 || i == 14 || i == 18);
        end
        scan_req_i = 1'b0;
        vectors += 3;
        if (busy_mid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL b2b_busy_during_reqs: got %b, expected 1", busy_mid);
        end
        if (falls != 2) begin
            miscompares++; $display("[TB] FAIL b2b_scan_count: got %0d, expected 2", falls);
        end
        if (valids != exp_valids) begin
            miscompares++; $display("[TB] FAIL b2b_valid_count: got %0d, expected %0d", valids, exp_valids);
        end
    endtask

    task automatic test_req_with_expiry();
        int falls = 0, fall_j = -1;
        logic prev_l = 1'b1, found = 1'b0;
        logic [NUM_BITS-1:0] e;
        auto_en_i = 1'b1;
        for (int i = 0; i < PERIOD_CLKS + SCAN_CLKS + 10 && !found; i++) begin
            @(negedge clk_i);
            if (!joy_load_o && prev_l) found = 1'b1;
            prev_l = joy_load_o;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("[TB] FAIL expiry_wait: got no auto scan, expected one within %0d clocks", PERIOD_CLKS + SCAN_CLKS + 10);
            auto_en_i = 1'b0;
            return;
        end
        for (int j = 1; j < PERIOD_CLKS + 200; j++) begin
            @(negedge clk_i);
            if (!joy_load_o && prev_l) begin
                falls++;
                if (fall_j < 0) fall_j = j;
            end
            prev_l = joy_load_o;
            if (frame_valid_o) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL expiry_frame: valid with frame %h, nothing expected", frame_o);
                end else begin
                    e = exp_q.pop_front();
                    if (frame_o !== e) begin
                        miscompares++;
                        $display("[TB] FAIL expiry_frame: got %h, expected %h", frame_o, e);
                    end
                end
            end
            scan_req_i = (j == PERIOD_CLKS - 1);
            if (j == PERIOD_CLKS + 1) auto_en_i = 1'b0;
        end
        scan_req_i = 1'b0;
        vectors += 2;
        if (falls != 1) begin
            miscompares++; $display("[TB] FAIL expiry_scan_count: got %0d, expected 1", falls);
        end
        if (fall_j != PERIOD_CLKS) begin
            miscompares++; $display("[TB] FAIL expiry_start_time: got %0d, expected %0d", fall_j, PERIOD_CLKS);
        end
    endtask

    task automatic test_reset_mid_shift();
        int rises = 0, valids = 0, frame_moves = 0, exp_q_len;
        logic prev_c = 1'b0;
`ifdef JOY_SCAN_DEBOUNCE_EN
        exp_q_len = 0;
`else
        exp_q_len = 1;
`endif
        chain_word = 8'h0F;
        @(negedge clk_i) scan_req_i = 1'b1;
        for (int i = 0; i < 100 && rises < 3; i++) begin
            @(negedge clk_i);
            scan_req_i = 1'b0;
            if (joy_clk_o && !prev_c) rises++;
            prev_c = joy_clk_o;
        end
        vectors++;
        if (rises != 3) begin
            miscompares++; $display("[TB] FAIL midshift_wait: got %0d chain clocks, expected 3", rises);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        vectors += 5;
        if (joy_load_o !== 1'b1) begin miscompares++; $display("[TB] FAIL midshift_load: got %b, expected 1", joy_load_o); end
        if (joy_clk_o !== 1'b0) begin miscompares++; $display("[TB] FAIL midshift_jclk: got %b, expected 0", joy_clk_o); end
        if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL midshift_busy: got %b, expected 0", busy_o); end
        if (frame_o !== 8'hFF) begin miscompares++; $display("[TB] FAIL midshift_frame: got %h, expected ff", frame_o); end
        if (frame_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL midshift_valid: got %b, expected 0", frame_valid_o); end
        rst_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (frame_valid_o) valids++;
            if (frame_o !== 8'hFF) frame_moves++;
        end
        vectors += 3;
        if (valids != 0) begin miscompares++; $display("[TB] FAIL midshift_no_valid: got %0d, expected 0", valids); end
        if (frame_moves != 0) begin miscompares++; $display("[TB] FAIL midshift_frame_hold: got %0d changes, expected 0", frame_moves); end
        if (exp_q.size() != exp_q_len) begin
            miscompares++; $display("[TB] FAIL midshift_queue: got %0d pending frames, expected %0d", exp_q.size(), exp_q_len);
        end
        exp_q.delete();
    endtask

    task automatic test_frame_sequence();
        logic [NUM_BITS-1:0] words[3] = '{8'h12, 8'h34, 8'h34};
        int exp_valid[3];
        logic [NUM_BITS-1:0] exp_frame[3];
        logic [NUM_BITS-1:0] e;
        logic seen_busy, done;
        int valids;
`ifdef JOY_SCAN_DEBOUNCE_EN
        exp_valid = '{0, 0, 1};
        exp_frame = '{8'hFF, 8'hFF, 8'h34};
`else
        exp_valid = '{1, 1, 1};
        exp_frame = '{8'h12, 8'h34, 8'h34};
`endif
        for (int s = 0; s < 3; s++) begin
            chain_word = words[s];
            valids = 0;
            seen_busy = 1'b0;
            done = 1'b0;
            @(negedge clk_i) scan_req_i = 1'b1;
            for (int i = 0; i < 150 && !done; i++) begin
                @(negedge clk_i);
                scan_req_i = 1'b0;
                if (busy_o) seen_busy = 1'b1;
                else if (seen_busy) done = 1'b1;
                if (frame_valid_o) begin
                    valids++;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("[TB] FAIL seq_frame_%0d: valid with frame %h, nothing expected", s, frame_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (frame_o !== e) begin
                            miscompares++;
                            $display("[TB] FAIL seq_frame_%0d: got %h, expected %h", s, frame_o, e);
                        end
                    end
                end
            end
            vectors += 3;
            if (!done) begin
                miscompares++; $display("[TB] FAIL seq_done_%0d: got no scan completion, expected one within 150 clocks", s);
            end
            if (valids != exp_valid[s]) begin
                miscompares++; $display("[TB] FAIL seq_valid_%0d: got %0d, expected %0d", s, valids, exp_valid[s]);
            end
            if (frame_o !== exp_frame[s]) begin
                miscompares++; $display("[TB] FAIL seq_frame_out_%0d: got %h, expected %h", s, frame_o, exp_frame[s]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_scan();
        test_auto_period();
        test_back_to_back();
        test_req_with_expiry();
        test_reset_mid_shift();
        test_frame_sequence();
        repeat (5) @(negedge clk_i);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d frames never published, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
